// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, opcode/funct values and ALU operation codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LUI = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps opcode+funct to an ALU operation, shift flag and
// an instruction-valid flag used to trap unsupported encodings.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       shift,
  output logic       valid
);

  // Pure decode; any unlisted encoding drops valid.
  always_comb begin
    alu_op = ALU_ADD;
    shift  = 1'b0;
    valid  = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLL: begin
            alu_op = ALU_SLL;
            shift  = 1'b1;
          end
          FN_SRL: begin
            alu_op = ALU_SRL;
            shift  = 1'b1;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI: alu_op = ALU_ADD;
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      OP_XORI: alu_op = ALU_XOR;
      OP_LUI:  alu_op = ALU_LUI;
      OP_LW,
      OP_SW,
      OP_J:    alu_op = ALU_ADD;
      OP_BEQ,
      OP_BNE:  alu_op = ALU_SUB;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: registered FSM state with
// combinational datapath controls; memory states can stall.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 i_or_d,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic                 shift,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           state,
  output logic                 illegal
);

  state_t  r_state;
  state_t  w_next;
  alu_op_t r_op;
  logic    r_shift;
  logic    r_bne;
  logic    r_sw;
  alu_op_t w_dec_op;
  logic    w_dec_shift;
  logic    w_dec_valid;
  alu_op_t w_op;
  logic    w_rdy;

  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (w_dec_op),
    .shift  (w_dec_shift),
    .valid  (w_dec_valid)
  );

  // State register; reset wins over any pending memory wait.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Capture decoded instruction info while the IR is being decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= ALU_ADD;
      r_shift <= 1'b0;
      r_bne   <= 1'b0;
      r_sw    <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_op    <= w_dec_op;
      r_shift <= w_dec_shift;
      r_bne   <= (opcode == OP_BNE);
      r_sw    <= (opcode == OP_SW);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:     if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_dec_valid) begin
          unique case (opcode)
            OP_RTYPE: w_next = S_R_EXEC;
            OP_ADDI,
            OP_ANDI,
            OP_ORI,
            OP_XORI,
            OP_LUI:   w_next = S_I_EXEC;
            OP_LW,
            OP_SW:    w_next = S_MEM_ADDR;
            OP_BEQ,
            OP_BNE:   w_next = S_BRANCH;
            OP_J:     w_next = S_JUMP;
            default:  w_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR:  w_next = r_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (w_rdy) w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (w_rdy) w_next = S_FETCH;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_I_EXEC:    w_next = S_I_WB;
      S_I_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; enables are masked during reset.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    shift      = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    w_op       = ALU_ADD;
    unique case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_rdy;
        pc_write  = w_rdy;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~w_dec_valid;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        w_op      = r_op;
        shift     = r_shift;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_op      = r_op;
        shift     = r_shift;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_op      = r_op;
      end
      S_I_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        w_op      = ALU_SUB;
        pc_write  = r_bne ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign alu_control = {{(ALUCTRL_W-3){1'b0}}, w_op};
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-cycle expected control words are queued
// as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, mem_to_reg, reg_dst, alu_src_a, shift;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control;
  logic [3:0] state;
  logic       illegal;

  int n_chk  = 0;
  int n_fail = 0;
  string      r_tag = "";
  logic [22:0] q[$];
  logic [22:0] r_exp;
  logic [22:0] w_obs;

  multicycle_control #(.ALUCTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .i_or_d(i_or_d),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .shift(shift),
    .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .state(state),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign w_obs = {state, pc_write, ir_write, mem_read,
                  mem_write, reg_write, i_or_d, mem_to_reg,
                  reg_dst, alu_src_a, shift, alu_src_b,
                  pc_src, alu_control, illegal};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // word: state|pcw irw mr mw rw|iod m2r rdst asa sh|asb|pcs|alu|ill
  function automatic logic [22:0] ev(
    input logic [3:0] st, input logic [4:0] en,
    input logic [4:0] sel, input logic [1:0] asb,
    input logic [1:0] pcs, input logic [3:0] aluc,
    input logic ill);
    return {st, en, sel, asb, pcs, aluc, ill};
  endfunction

  function automatic logic [22:0] e_fetch(input logic r);
    return ev(4'd0, {r, r, 3'b100}, 5'b0, 2'b01, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_dec(input logic ill);
    return ev(4'd1, 5'b0, 5'b0, 2'b11, 2'b00, 4'd0, ill);
  endfunction
  function automatic logic [22:0] e_rex(input logic [3:0] a,
                                        input logic sh);
    return ev(4'd6, 5'b0, {4'b0001, sh}, 2'b00, 2'b00, a, 1'b0);
  endfunction
  function automatic logic [22:0] e_rwb(input logic [3:0] a,
                                        input logic sh);
    return ev(4'd7, 5'b00001, {4'b0010, sh}, 2'b00, 2'b00, a, 1'b0);
  endfunction
  function automatic logic [22:0] e_iex(input logic [3:0] a);
    return ev(4'd8, 5'b0, 5'b00010, 2'b10, 2'b00, a, 1'b0);
  endfunction
  function automatic logic [22:0] e_iwb();
    return ev(4'd9, 5'b00001, 5'b0, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_madr();
    return ev(4'd2, 5'b0, 5'b00010, 2'b10, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_mrd();
    return ev(4'd3, 5'b00100, 5'b10000, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_mwb();
    return ev(4'd4, 5'b00001, 5'b01000, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_mwr(input logic w);
    return ev(4'd5, {3'b000, w, 1'b0}, 5'b10000, 2'b00, 2'b00,
              4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_br(input logic p);
    return ev(4'd10, {p, 4'b0}, 5'b00010, 2'b00, 2'b01, 4'd1, 1'b0);
  endfunction
  function automatic logic [22:0] e_jmp();
    return ev(4'd11, 5'b10000, 5'b0, 2'b00, 2'b10, 4'd0, 1'b0);
  endfunction
  function automatic logic [22:0] e_rst();
    return ev(4'd0, 5'b0, 5'b0, 2'b01, 2'b00, 4'd0, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      r_exp = q.pop_front();
      chk(r_tag, {9'b0, w_obs}, {9'b0, r_exp});
    end
  end

  task automatic step(input string t, input logic rdy,
                      input logic [22:0] e);
    mem_ready = rdy;
    r_tag     = t;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_r(input string t, input logic [5:0] f,
                      input logic [3:0] a, input logic sh);
    opcode = 6'b000000;
    funct  = f;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b0));
    step({t, ".exec"},  1'b1, e_rex(a, sh));
    step({t, ".wb"},    1'b1, e_rwb(a, sh));
  endtask

  task automatic do_i(input string t, input logic [5:0] op,
                      input logic [3:0] a);
    opcode = op;
    funct  = 6'b111111;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b0));
    step({t, ".exec"},  1'b1, e_iex(a));
    step({t, ".wb"},    1'b1, e_iwb());
  endtask

  task automatic do_lw(input string t, input int waits);
    opcode = 6'b100011;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b0));
    step({t, ".addr"},  1'b1, e_madr());
    for (int i = 0; i < waits; i++)
      step({t, ".rdwait"}, 1'b0, e_mrd());
    step({t, ".rd"},    1'b1, e_mrd());
    step({t, ".wb"},    1'b1, e_mwb());
  endtask

  task automatic do_sw(input string t, input int waits);
    opcode = 6'b101011;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b0));
    step({t, ".addr"},  1'b1, e_madr());
    for (int i = 0; i < waits; i++)
      step({t, ".wrwait"}, 1'b0, e_mwr(1'b1));
    step({t, ".wr"},    1'b1, e_mwr(1'b1));
  endtask

  task automatic do_br(input string t, input logic [5:0] op,
                       input logic z, input logic p);
    opcode = op;
    zero   = z;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b0));
    step({t, ".br"},    1'b1, e_br(p));
    zero = 1'b0;
  endtask

  task automatic do_bad(input string t, input logic [5:0] op,
                        input logic [5:0] f);
    opcode = op;
    funct  = f;
    step({t, ".fetch"}, 1'b1, e_fetch(1'b1));
    step({t, ".dec"},   1'b1, e_dec(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    opcode    = 6'b0;
    funct     = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", 1'b1, e_rst());
    step("rst1", 1'b1, e_rst());
    rst = 1'b0;

    do_r("add", 6'b100000, 4'd0, 1'b0);
    do_r("sub", 6'b100010, 4'd1, 1'b0);
    do_r("and", 6'b100100, 4'd2, 1'b0);
    do_r("or",  6'b100101, 4'd3, 1'b0);
    do_r("xor", 6'b100110, 4'd4, 1'b0);
    do_r("sll", 6'b000000, 4'd6, 1'b1);
    do_r("srl", 6'b000010, 4'd7, 1'b1);

    do_i("addi", 6'b001000, 4'd0);
    do_i("andi", 6'b001100, 4'd2);
    do_i("ori",  6'b001101, 4'd3);
    do_i("xori", 6'b001110, 4'd4);
    do_i("lui",  6'b001111, 4'd5);

    do_lw("lw0", 0);
    do_lw("lw3", 3);
    do_sw("sw0", 0);
    do_sw("sw2", 2);

    do_br("beq_z0", 6'b000100, 1'b0, 1'b0);
    do_br("beq_z1", 6'b000100, 1'b1, 1'b1);
    do_br("bne_z0", 6'b000101, 1'b0, 1'b1);
    do_br("bne_z1", 6'b000101, 1'b1, 1'b0);

    opcode = 6'b000010;
    step("j.fwait", 1'b0, e_fetch(1'b0));
    step("j.fwait", 1'b0, e_fetch(1'b0));
    step("j.fetch", 1'b1, e_fetch(1'b1));
    step("j.dec",   1'b1, e_dec(1'b0));
    step("j.jmp",   1'b1, e_jmp());

    do_bad("bad_op",  6'b111111, 6'b100000);
    do_bad("bad_fn",  6'b000000, 6'b000001);
    do_bad("bad_op3", 6'b000011, 6'b000000);
    do_r("after_bad", 6'b100000, 4'd0, 1'b0);

    opcode = 6'b101011;
    step("swr.fetch", 1'b1, e_fetch(1'b1));
    step("swr.dec",   1'b1, e_dec(1'b0));
    step("swr.addr",  1'b1, e_madr());
    step("swr.wait",  1'b0, e_mwr(1'b1));
    rst = 1'b1;
    step("swr.rst",   1'b0, e_mwr(1'b0));
    step("swr.rst2",  1'b0, e_rst());
    rst = 1'b0;
    do_r("after_rst", 6'b100010, 4'd1, 1'b0);

    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUCTRL_W, default 4: width of alu_control; SHALL be >= 4.
REQ-002 Parameter MEM_WAIT_EN, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 opcode  in  6  instruction bits [31:26], sampled from IR in DECODE.
REQ-006 funct  in  6  instruction bits [5:0].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-009 Enable outputs, each out 1: pc_write, ir_write, mem_read, mem_write, reg_write.
REQ-010 Select outputs, each out 1: i_or_d, mem_to_reg, reg_dst, alu_src_a, shift.
REQ-011 alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-012 pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 alu_control  out  ALUCTRL_W  ADD=0, SUB=1, AND=2, OR=3, XOR=4, LUI=5, SLL=6, SRL=7, zero-extended to ALUCTRL_W.
REQ-014 state  out  4  current state encoding, for debug.
REQ-015 illegal  out  1  one-cycle pulse on an unsupported opcode/funct.

Function
REQ-016 States, encoded 0..11: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-017 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00; ir_write=pc_write=mem_ready; state -> DECODE only when mem_ready=1, else holds.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target); no enables; next state by opcode.
REQ-019 Decode map: 000000 -> R_EXEC; 001000/001100/001101/001110/001111 -> I_EXEC; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010 -> JUMP; any other -> FETCH with illegal=1 for that DECODE cycle.
REQ-020 R-type funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000000 SLL, 000010 SRL; any other funct -> FETCH from DECODE, illegal=1, no register write.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_control per funct; shift=1 for SLL/SRL only; -> R_WB.
REQ-022 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_control and shift held from R_EXEC; -> FETCH.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10; ADDI=ADD, ANDI=AND, ORI=OR, XORI=XOR, LUI=LUI; -> I_WB.
REQ-024 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-025 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; LW -> MEM_READ, SW -> MEM_WRITE.
REQ-026 MEM_READ: mem_read=1, i_or_d=1; -> MEM_WB on mem_ready, else holds.
REQ-027 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
REQ-028 MEM_WRITE: mem_write=1, i_or_d=1; -> FETCH on mem_ready, else holds; mem_write stays high while waiting.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; pc_write = zero for BEQ, !zero for BNE; -> FETCH.
REQ-030 JUMP: pc_src=10, pc_write=1; -> FETCH.
REQ-031 Outputs not named for a state SHALL be 0.
REQ-032 Cycle counts with mem_ready tied high: R/I-type 4, LW 5, SW 4, branch 3, jump 3.

Reset
REQ-033 rst=1 at a clock edge SHALL force state=FETCH, regardless of the current state, including a pending memory wait.
REQ-034 While rst=1, every enable output SHALL be 0: pc_write, ir_write, mem_read, mem_write, reg_write; illegal SHALL also be 0.
REQ-035 The first FETCH SHALL begin on the first edge after rst deasserts.

Structure
REQ-036 A shared package SHALL hold the state encoding, the opcode/funct constants, and the ALU operation codes.
REQ-037 One sub-module, alu_decoder (opcode+funct -> alu_control, shift, valid), SHALL be instantiated; the FSM SHALL use a registered state and combinational outputs.

Verification
REQ-038 ADD, funct 100000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in R_WB; alu_control=0.
REQ-039 LW with mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, mem_read=1 throughout, then MEM_WB with mem_to_reg=1.
REQ-040 BEQ with zero=0 -> pc_write=0 in BRANCH; BNE with zero=0 -> pc_write=1, pc_src=01.
REQ-041 Opcode 111111 -> illegal=1 for one cycle in DECODE, then FETCH, no write enables.
REQ-042 rst asserted in MEM_WRITE while waiting -> next state FETCH, mem_write=0 while rst=1.
REQ-043 SRL, funct 000010 -> shift=1, alu_control=7 in R_EXEC and R_WB.
